// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link (mux-side transmitter and demux receiver).
// Holds state encoding, control bundle, default geometry and a slot-width helper.
package tdm_pkg;

    // Default link geometry, shared with the transmitter side.
    localparam int TDM_NCH = 4;
    localparam int TDM_W   = 8;

    // Receiver framing state.
    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } tdm_state_e;

    // Per-sample actions decoded by the receiver FSM.
    typedef struct packed {
        logic wr_en;
        logic wr_slot0;
        logic ld1;
        logic inc;
        logic done;
        logic err;
    } tdm_ctl_t;

    // Bits needed to index n slots; never less than one.
    function automatic int tdm_clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM receiver: clear, load-1, increment, terminal count.
// Ports: clk, rst_n, clr, load1, inc -> slot (current slot), tc (slot == NCH-1).
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int NCH = TDM_NCH,
    parameter int SW  = tdm_clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load1,
    input  logic          inc,
    output logic [SW-1:0] slot,
    output logic          tc
);

    localparam logic [SW-1:0] LAST = SW'(NCH - 1);
    localparam logic [SW-1:0] ONE  = SW'(1);

    assign tc = (slot == LAST);

    // Increment at terminal count wraps to 0, so the count stays below NCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= ONE;
        end else if (inc) begin
            slot <= tc ? '0 : slot + ONE;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: locks to frame_sync, de-interleaves NCH channels of W bits.
// Ports: din/din_valid/frame_sync in; out, out_valid, sync_err, locked, frame_cnt out.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NCH   = TDM_NCH,
    parameter int W     = TDM_W,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       din,
    input  logic               din_valid,
    input  logic               frame_sync,
    output logic [NCH*W-1:0]   out,
    output logic               out_valid,
    output logic               sync_err,
    output logic               locked,
    output logic [CNT_W-1:0]   frame_cnt
);

    localparam int SW = tdm_clog2(NCH);

    tdm_state_e        state;
    tdm_state_e        state_nxt;
    tdm_ctl_t          ctl;
    logic [SW-1:0]     slot;
    logic [SW-1:0]     wr_idx;
    logic              tc;
    logic              slot_zero;
    logic [NCH*W-1:0]  shadow;
    logic [NCH*W-1:0]  frame_cat;

    assign slot_zero = (slot == '0);
    assign locked    = (state == ST_LOCK);

    tdm_slot_ctr #(
        .NCH (NCH),
        .SW  (SW)
    ) u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctl.done),
        .load1 (ctl.ld1),
        .inc   (ctl.inc),
        .slot  (slot),
        .tc    (tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (din_valid) begin
            unique case (state)
                ST_HUNT: begin
                    if (frame_sync) begin
                        state_nxt = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (!frame_sync && slot_zero) begin
                        state_nxt = ST_HUNT;
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
        end
    end

    // Action decode. A sync always restarts the frame at slot 0, so a
    // sync arriving on the last slot is an early sync, never a completion.
    always_comb begin
        ctl = '0;
        if (din_valid) begin
            unique case (state)
                ST_HUNT: begin
                    if (frame_sync) begin
                        ctl.wr_en    = 1'b1;
                        ctl.wr_slot0 = 1'b1;
                        ctl.ld1      = 1'b1;
                    end
                end
                ST_LOCK: begin
                    unique case (1'b1)
                        frame_sync: begin
                            ctl.wr_en    = 1'b1;
                            ctl.wr_slot0 = 1'b1;
                            ctl.ld1      = 1'b1;
                            ctl.err      = !slot_zero;
                        end
                        !frame_sync && slot_zero: begin
                            ctl.err = 1'b1;
                        end
                        !frame_sync && !slot_zero && tc: begin
                            ctl.done = 1'b1;
                        end
                        !frame_sync && !slot_zero && !tc: begin
                            ctl.wr_en = 1'b1;
                            ctl.inc   = 1'b1;
                        end
                        default: ctl = '0;
                    endcase
                end
                default: ctl = '0;
            endcase
        end
    end

    assign wr_idx = ctl.wr_slot0 ? '0 : slot;

    // The last sample bypasses the shadow and lands in out directly.
    always_comb begin
        frame_cat = shadow;
        frame_cat[(NCH-1)*W +: W] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (ctl.wr_en) begin
            shadow[int'(wr_idx)*W +: W] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            out_valid <= ctl.done;
            sync_err  <= ctl.err;
            if (ctl.done) begin
                out       <= frame_cat;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (NCH=4, W=8, CNT_W=8).
// Expected frames are queued at stimulus time and checked as out_valid fires.
module tb_tdm_demux;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        frame_sync;
    logic [31:0] out;
    logic        out_valid;
    logic        sync_err;
    logic        locked;
    logic [7:0]  frame_cnt;

    typedef struct {
        logic [31:0] frame;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  exp_cnt;
    int          errors;
    int          checks;

    tdm_demux #(
        .NCH   (4),
        .W     (8),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .out        (out),
        .out_valid  (out_valid),
        .sync_err   (sync_err),
        .locked     (locked),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every out_valid pulse must match the queue head.
    always @(negedge clk) begin
        if (rst_n && (out_valid || sync_err)) begin
            checks++;
            if (out_valid && sync_err) begin
                errors++;
                $display("FAIL both_pulses out_valid=%b sync_err=%b exp=not both",
                         out_valid, sync_err);
            end
        end
        if (rst_n && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame out=%h (no frame expected)", out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out !== e.frame || frame_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL sb_frame out=%h cnt=%0d exp out=%h cnt=%0d",
                             out, frame_cnt, e.frame, e.cnt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [7:0] d, input logic fs);
        din        = d;
        frame_sync = fs;
        din_valid  = 1'b1;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_frame(input logic [31:0] f, input int gap);
        exp_t e;
        for (int k = 1; k < 4; k++) begin
            if (k == 3) begin
                e.frame = f;
                e.cnt   = exp_cnt + 8'd1;
                sb.push_back(e);
                exp_cnt = exp_cnt + 8'd1;
            end
            drive(f[k*8 +: 8], 1'b0);
            if (k < 3) idle(gap);
        end
    endtask

    task automatic send_frame(input logic [31:0] f, input int gap);
        drive(f[7:0], 1'b1);
        idle(gap);
        finish_frame(f, gap);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        exp_cnt = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out !== 32'h0 || out_valid !== 1'b0 || sync_err !== 1'b0 ||
            locked !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state out=%h ov=%b se=%b lk=%b cnt=%0d exp all 0",
                     out, out_valid, sync_err, locked, frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        send_frame(32'h44332211, 0);
        checks++;
        if (out_valid !== 1'b1 || out !== 32'h44332211 || frame_cnt !== 8'd1 ||
            locked !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first ov=%b out=%h cnt=%0d lk=%b exp 1 44332211 1 1",
                     out_valid, out, frame_cnt, locked);
        end
        send_frame(32'h44332211, 0);
        checks++;
        if (out_valid !== 1'b1 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL b2b_second ov=%b cnt=%0d exp 1 2", out_valid, frame_cnt);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0 || out !== 32'h44332211) begin
            errors++;
            $display("FAIL b2b_hold ov=%b out=%h exp 0 44332211", out_valid, out);
        end
    endtask

    task automatic test_hunt_drop();
        apply_reset();
        drive(8'hAA, 1'b0);
        drive(8'hBB, 1'b0);
        checks++;
        if (sync_err !== 1'b0 || out_valid !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL hunt_drop se=%b ov=%b lk=%b exp 0 0 0",
                     sync_err, out_valid, locked);
        end
        send_frame(32'h5A6B7C8D, 0);
        checks++;
        if (out !== 32'h5A6B7C8D || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL hunt_frame out=%h cnt=%0d exp 5a6b7c8d 1", out, frame_cnt);
        end
    endtask

    task automatic test_early_sync();
        drive(8'h01, 1'b1);
        drive(8'h02, 1'b0);
        drive(8'h05, 1'b1);
        checks++;
        if (sync_err !== 1'b1 || out_valid !== 1'b0 || out !== 32'h5A6B7C8D ||
            locked !== 1'b1) begin
            errors++;
            $display("FAIL early_sync se=%b ov=%b out=%h lk=%b exp 1 0 5a6b7c8d 1",
                     sync_err, out_valid, out, locked);
        end
        finish_frame(32'h08070605, 0);
        checks++;
        if (out !== 32'h08070605 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL early_resync out=%h cnt=%0d exp 08070605 2", out, frame_cnt);
        end
    endtask

    task automatic test_missing_sync();
        drive(8'h99, 1'b0);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL missing_sync se=%b lk=%b ov=%b exp 1 0 0",
                     sync_err, locked, out_valid);
        end
        idle(1);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL missing_pulse se=%b exp 0", sync_err);
        end
        send_frame(32'hA1B2C3D4, 0);
        checks++;
        if (out !== 32'hA1B2C3D4 || locked !== 1'b1) begin
            errors++;
            $display("FAIL relock out=%h lk=%b exp a1b2c3d4 1", out, locked);
        end
    endtask

    task automatic test_gaps();
        send_frame(32'h44332211, 3);
        checks++;
        if (out_valid !== 1'b1 || out !== 32'h44332211) begin
            errors++;
            $display("FAIL gap_frame ov=%b out=%h exp 1 44332211", out_valid, out);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_pulse ov=%b exp 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive(8'h11, 1'b1);
        drive(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 32'h0 || frame_cnt !== 8'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid out=%h cnt=%0d lk=%b exp 0 0 0",
                     out, frame_cnt, locked);
        end
        exp_cnt = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(32'hCAFEBABE, 0);
        checks++;
        if (frame_cnt !== 8'd1 || out !== 32'hCAFEBABE) begin
            errors++;
            $display("FAIL reset_fresh cnt=%0d out=%h exp 1 cafebabe", frame_cnt, out);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 255; i++) begin
            send_frame($urandom, 0);
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL cnt_wrap cnt=%0d exp 0", frame_cnt);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        exp_cnt    = '0;
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        test_reset();
        test_back_to_back();
        test_hunt_drop();
        test_early_sync();
        test_missing_sync();
        test_gaps();
        test_reset_mid();
        test_wrap();
        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d exp 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
